// File: rtl/mul_pkg.sv
// Shared types for the sequential Booth multiplier.
// Holds the FSM state encoding and the default operand width.
package mul_pkg;

  localparam int WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/booth_step.sv
// One combinational radix-2 Booth step: add/sub M, then shift right.
// Ports: u, m, v0, x_prev in; u_nxt, v_msb, x_nxt out.
module booth_step
  import mul_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] u,
  input  logic [WIDTH-1:0] m,
  input  logic             v0,
  input  logic             x_prev,
  output logic [WIDTH-1:0] u_nxt,
  output logic             v_msb,
  output logic             x_nxt
);

  logic             sub;
  logic             add;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [WIDTH-1:0] s;
  logic             co;
  logic             co_prev;
  logic             msb;

  assign sub = v0 & ~x_prev;
  assign add = ~v0 & x_prev;

  always_comb begin
    b   = '0;
    cin = 1'b0;
    unique case (1'b1)
      sub: begin
        b   = ~m;
        cin = 1'b1;
      end
      add: b = m;
      default: ;
    endcase
  end

  cla_add #(.WIDTH(WIDTH)) u_add (
    .a     (u),
    .b     (b),
    .cin   (cin),
    .sum   (s),
    .co    (co),
    .c_msb (co_prev)
  );

  // True sign of the WIDTH+1-bit sum survives signed overflow.
  assign msb = (sub | add)
             ? (s[WIDTH-1] ^ (co ^ co_prev))
             : u[WIDTH-1];

  assign u_nxt = {msb, s[WIDTH-1:1]};
  assign v_msb = s[0];
  assign x_nxt = v0;

endmodule

// File: rtl/cla_add.sv
// WIDTH-bit adder built from 4-bit carry-lookahead groups.
// Ports: a, b, cin in; sum, co (carry out), c_msb (carry into MSB) out.
module cla_add #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             co,
  output logic             c_msb
);

  localparam int NG = WIDTH / 4;

  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;
  logic [WIDTH:0]   c;

  assign g = a & b;
  assign p = a ^ b;

  always_comb begin
    c    = '0;
    c[0] = cin;
    for (int k = 0; k < NG; k++) begin
      c[4*k+1] = g[4*k]
               | (p[4*k] & c[4*k]);
      c[4*k+2] = g[4*k+1]
               | (p[4*k+1] & g[4*k])
               | (p[4*k+1] & p[4*k] & c[4*k]);
      c[4*k+3] = g[4*k+2]
               | (p[4*k+2] & g[4*k+1])
               | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k]
                  & c[4*k]);
      c[4*k+4] = g[4*k+3]
               | (p[4*k+3] & g[4*k+2])
               | (p[4*k+3] & p[4*k+2] & g[4*k+1])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1]
                  & g[4*k])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1]
                  & p[4*k] & c[4*k]);
    end
  end

  assign sum   = p ^ c[WIDTH-1:0];
  assign co    = c[WIDTH];
  assign c_msb = c[WIDTH-1];

endmodule

// File: rtl/booth_seq_mul.sv
// Sequential signed radix-2 Booth multiplier, one step per clock.
// Ports: clk, reset_n, op_start, op_clear, operands in; op_done, result out.
module booth_seq_mul
  import mul_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               op_start,
  input  logic               op_clear,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               op_done,
  output logic [2*WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH);

  state_t           state;
  logic [WIDTH-1:0] u_q;
  logic [WIDTH-1:0] v_q;
  logic [WIDTH-1:0] m_q;
  logic             x_q;
  logic [CW-1:0]    cnt_q;

  logic [WIDTH-1:0] u_nxt;
  logic             v_msb;
  logic             x_nxt;
  logic [WIDTH-1:0] v_nxt;

  booth_step #(.WIDTH(WIDTH)) u_step (
    .u      (u_q),
    .m      (m_q),
    .v0     (v_q[0]),
    .x_prev (x_q),
    .u_nxt  (u_nxt),
    .v_msb  (v_msb),
    .x_nxt  (x_nxt)
  );

  assign v_nxt = {v_msb, v_q[WIDTH-1:1]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      u_q     <= '0;
      v_q     <= '0;
      m_q     <= '0;
      x_q     <= 1'b0;
      cnt_q   <= '0;
      op_done <= 1'b0;
      result  <= '0;
    end else if (op_clear) begin
      state   <= IDLE;
      u_q     <= '0;
      v_q     <= '0;
      x_q     <= 1'b0;
      cnt_q   <= '0;
      op_done <= 1'b0;
      result  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (op_start) begin
            m_q   <= multiplicand;
            u_q   <= '0;
            v_q   <= multiplier;
            x_q   <= 1'b0;
            cnt_q <= '0;
            state <= EXEC;
          end
        end
        EXEC: begin
          u_q   <= u_nxt;
          v_q   <= v_nxt;
          x_q   <= x_nxt;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) begin
            state   <= DONE;
            op_done <= 1'b1;
            result  <= {u_nxt, v_nxt};
          end
        end
        DONE: ;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_seq_mul.sv
// Self-checking bench for booth_seq_mul.
// Cycle model of the handshake plus directed literal products.
module tb_booth_seq_mul;

  localparam int W = 32;

  logic           clk = 1'b0;
  logic           reset_n = 1'b1;
  logic           op_start = 1'b0;
  logic           op_clear = 1'b0;
  logic [W-1:0]   multiplicand = '0;
  logic [W-1:0]   multiplier = '0;
  logic           op_done;
  logic [2*W-1:0] result;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  booth_seq_mul #(.WIDTH(W)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .op_start     (op_start),
    .op_clear     (op_clear),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .op_done      (op_done),
    .result       (result)
  );

  function automatic logic [63:0] prod(
    input logic [W-1:0] a,
    input logic [W-1:0] b
  );
    longint x;
    longint y;
    x = $signed(a);
    y = $signed(b);
    return 64'(x * y);
  endfunction

  // Model: busy for W edges after an accepted start, then done.
  bit          mb = 1'b0;
  bit          md = 1'b0;
  int          ml = 0;
  logic [63:0] mp = '0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mb = 1'b0;
      md = 1'b0;
      ml = 0;
      mp = '0;
    end else if (op_clear) begin
      mb = 1'b0;
      md = 1'b0;
      ml = 0;
      mp = '0;
    end else if (!mb && !md && op_start) begin
      mb = 1'b1;
      ml = W;
      mp = prod(multiplicand, multiplier);
    end else if (mb) begin
      ml = ml - 1;
      if (ml == 0) begin
        mb = 1'b0;
        md = 1'b1;
      end
    end
  end

  task automatic chk(
    input string       nm,
    input logic [63:0] act,
    input logic [63:0] exp
  );
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("cmp_done", {63'd0, op_done}, {63'd0, md});
    chk("cmp_result", result, md ? mp : 64'd0);
  end

  task automatic start_op(
    input logic [W-1:0] a,
    input logic [W-1:0] b
  );
    @(negedge clk);
    multiplicand = a;
    multiplier = b;
    op_start = 1'b1;
    @(negedge clk);
    op_start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!op_done && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic clear_op();
    @(negedge clk);
    op_clear = 1'b1;
    @(negedge clk);
    op_clear = 1'b0;
    chk("clr_done", {63'd0, op_done}, 64'd0);
    chk("clr_result", result, 64'd0);
  endtask

  task automatic run(
    input string       nm,
    input logic [W-1:0] a,
    input logic [W-1:0] b,
    input logic [63:0] exp
  );
    int n;
    start_op(a, b);
    wait_done(n);
    chk({nm, "_lat"}, 64'(n), 64'd32);
    chk(nm, result, exp);
    clear_op();
  endtask

  initial begin
    int n;
    #1 reset_n = 1'b0;
    #11;
    chk("rst_done", {63'd0, op_done}, 64'd0);
    chk("rst_result", result, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    run("p7xm3", 32'd7, 32'hFFFF_FFFD,
        64'hFFFF_FFFF_FFFF_FFEB);
    run("pminsq", 32'h8000_0000, 32'h8000_0000,
        64'h4000_0000_0000_0000);
    run("pmaxsq", 32'h7FFF_FFFF, 32'h7FFF_FFFF,
        64'h3FFF_FFFF_0000_0001);
    run("pzero", 32'd0, 32'h1234_5678, 64'd0);

    // abort after ten Booth steps
    start_op(32'd1234, 32'd5678);
    repeat (10) @(negedge clk);
    op_clear = 1'b1;
    @(negedge clk);
    op_clear = 1'b0;
    chk("abort_done", {63'd0, op_done}, 64'd0);
    chk("abort_result", result, 64'd0);
    repeat (30) @(negedge clk);
    chk("abort_stale", {63'd0, op_done}, 64'd0);
    run("p5x6", 32'd5, 32'd6, 64'd30);

    // start ignored in EXEC and DONE
    start_op(32'hFFFF_FFFB, 32'd9);
    repeat (5) @(negedge clk);
    multiplicand = 32'd100;
    multiplier = 32'd100;
    op_start = 1'b1;
    @(negedge clk);
    op_start = 1'b0;
    wait_done(n);
    chk("exec_start_lat", 64'(n), 64'd26);
    chk("exec_start_res", result,
        64'hFFFF_FFFF_FFFF_FFD3);
    multiplicand = 32'd3;
    multiplier = 32'd3;
    op_start = 1'b1;
    repeat (3) @(negedge clk);
    op_start = 1'b0;
    repeat (5) @(negedge clk);
    chk("done_start_done", {63'd0, op_done}, 64'd1);
    chk("done_start_res", result,
        64'hFFFF_FFFF_FFFF_FFD3);
    clear_op();

    // start and clear together in IDLE
    @(negedge clk);
    multiplicand = 32'd2;
    multiplier = 32'd2;
    op_start = 1'b1;
    op_clear = 1'b1;
    @(negedge clk);
    op_start = 1'b0;
    op_clear = 1'b0;
    repeat (40) @(negedge clk);
    chk("sc_done", {63'd0, op_done}, 64'd0);
    chk("sc_result", result, 64'd0);

    // async reset mid-EXEC
    start_op(32'd3, 32'd4);
    repeat (5) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_exec_done", {63'd0, op_done}, 64'd0);
    chk("arst_exec_res", result, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (35) @(negedge clk);
    chk("arst_abandon", {63'd0, op_done}, 64'd0);

    start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(n);
    chk("m1sq_lat", 64'(n), 64'd32);
    chk("m1sq", result, 64'd1);

    // async reset while holding a result
    #2 reset_n = 1'b0;
    #1;
    chk("arst_done_done", {63'd0, op_done}, 64'd0);
    chk("arst_done_res", result, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/booth_seq_mul.md
BOOTH_SEQ_MUL -- requirements
Module: booth_seq_mul

Interface
REQ-001 SHALL have parameter: WIDTH, 32, operand width in bits; multiple of 4; only 32 verified.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: op_start  input  1  start request; sampled only in IDLE.
REQ-005 SHALL have port: op_clear  input  1  synchronous abort/clear; highest priority after reset.
REQ-006 SHALL have port: multiplicand  input  WIDTH  signed two's-complement M; captured on accepted start.
REQ-007 SHALL have port: multiplier  input  WIDTH  signed two's-complement Q; captured on accepted start.
REQ-008 SHALL have port: op_done  output  1  high while in DONE; result valid.
REQ-009 SHALL have port: result  output  2*WIDTH  signed product M*Q.

Function
REQ-010 SHALL implement a 3-state FSM: IDLE, EXEC, DONE; state register only.
REQ-011 SHALL, in IDLE with op_start=1 and op_clear=0, latch M, load U=0, V=Q, x_prev=0, count=0, and enter EXEC.
REQ-012 SHALL, each EXEC edge, perform one radix-2 Booth step on {V[0],x_prev}: 10 -> U=U-M; 01 -> U=U+M; 00/11 -> U unchanged.
REQ-013 SHALL compute U+M and U-M with one WIDTH-bit carry-lookahead adder; subtract = ~M with carry-in 1.
REQ-014 SHALL arithmetic-shift {U',V,x_prev} right by one after the add; the bit shifted into U[WIDTH-1] is s[WIDTH-1] XOR (co XOR co_prev) on add/subtract steps, U[WIDTH-1] on no-op steps.
REQ-015 SHALL increment count each EXEC step; on the step where count==WIDTH-1, enter DONE.
REQ-016 SHALL have a latency of exactly WIDTH edges from the start-accept edge to op_done=1.
REQ-017 SHALL drive result={U,V} in DONE and hold it stable until op_clear or reset.
REQ-018 SHALL drive result to 0 in IDLE and EXEC.
REQ-019 SHALL ignore op_start in EXEC and DONE; a new operation requires op_clear to return to IDLE.
REQ-020 SHALL, on op_clear=1 in any state, enter IDLE, zero U, V, x_prev, count, and drive op_done=0 at the next edge.
REQ-021 SHALL, when op_start and op_clear are both 1 in IDLE, take op_clear and stay in IDLE.
REQ-022 SHALL produce the correct 2*WIDTH-bit product for all operand pairs, including M=Q=-2^(WIDTH-1).

Reset
REQ-023 SHALL, on reset_n=0, immediately force state=IDLE, U=V=M=0, x_prev=0, count=0, op_done=0, result=0.
REQ-024 SHALL abandon any in-progress EXEC on reset without producing a result.

Structure
REQ-025 SHALL place state encodings (IDLE, EXEC, DONE) and the WIDTH default in shared package mul_pkg.
REQ-026 SHALL split the design into one sub-module, booth_step:
  - combinational
  - inputs U, M, V[0], x_prev
  - outputs next U, next V MSB, next x_prev
  - contains the adder instance and the overflow-corrected sign bit
REQ-027 SHALL size count as clog2(WIDTH) bits.

Verification
REQ-028 SHALL cover: M=7, Q=-3, start -> after 32 edges op_done=1, result=0xFFFFFFFF_FFFFFFEB.
REQ-029 SHALL cover: M=Q=0x80000000 -> result=0x40000000_00000000; this exercises the overflow-corrected shift.
REQ-030 SHALL cover: M=Q=0x7FFFFFFF -> result=0x3FFFFFFF_00000001; M=0, Q=0x12345678 -> result=0.
REQ-031 SHALL cover: op_clear at EXEC step 10 -> next edge IDLE, op_done=0, result=0; a fresh start of 5*6 -> 30.
REQ-032 SHALL cover: op_start pulsed during EXEC and in DONE -> no restart, result unchanged; start+clear together in IDLE -> stays IDLE.
REQ-033 SHALL cover: reset_n low mid-EXEC (async, between edges) -> outputs 0 immediately; after release, next start computes -1*-1 = 1.
